// File: rtl/alu_pkg.sv
// Shared ALU definitions: logic-op encoding used by the op decoder and logic_unit.
package alu_pkg;

  typedef enum logic [1:0] {
    LOP_AND    = 2'd0,
    LOP_OR     = 2'd1,
    LOP_XOR    = 2'd2,
    LOP_PASS_A = 2'd3
  } logic_op_e;

endpackage : alu_pkg

// File: rtl/logic_core.sv
// Combinational bitwise op with optional inversion, plus zero/parity flags of the result.
module logic_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic_op_e        op,
  input  logic             invert,
  output logic [WIDTH-1:0] result_c,
  output logic             zero_c,
  output logic             parity_c
);

  logic [WIDTH-1:0] raw;

  always_comb begin
    raw = a;
    case (op)
      LOP_AND:    raw = a & b;
      LOP_OR:     raw = a | b;
      LOP_XOR:    raw = a ^ b;
      LOP_PASS_A: raw = a;
      default:    raw = a;
    endcase
  end

  assign result_c = invert ? ~raw : raw;
  assign zero_c   = (result_c == '0);
  assign parity_c = ^result_c;

endmodule : logic_core

// File: rtl/logic_unit.sv
// Handshaked, single-stage bitwise logic unit with an internal accumulator
// that can stand in for operand A.
module logic_unit
  import alu_pkg::*;
#(
  parameter int unsigned     WIDTH     = 8,
  parameter logic [WIDTH-1:0] ACC_RESET = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             acc_clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic_op_e        in_op,
  input  logic             in_invert,
  input  logic             in_acc,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_parity
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_eff;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] core_result;
  logic             core_zero;
  logic             core_parity;
  logic             accept;
  logic             emit;

  // Ready passes straight through from downstream so a full register can reload in the same cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign emit     = out_valid && out_ready;

  // A clear in the same cycle as an accumulate makes the op see the reset value.
  assign acc_eff = acc_clear ? ACC_RESET : acc;
  assign op_a    = in_acc ? acc_eff : in_a;

  logic_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a        (op_a),
    .b        (in_b),
    .op       (in_op),
    .invert   (in_invert),
    .result_c (core_result),
    .zero_c   (core_zero),
    .parity_c (core_parity)
  );

  // Output register: reload on accept, drain on emit, hold on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_zero   <= 1'b0;
      out_parity <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_result <= core_result;
      out_zero   <= core_zero;
      out_parity <= core_parity;
    end else if (emit) begin
      out_valid  <= 1'b0;
    end
  end

  // Accumulator: write-back of an accepted accumulate wins over a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= ACC_RESET;
    end else if (accept && in_acc) begin
      acc <= core_result;
    end else if (acc_clear) begin
      acc <= ACC_RESET;
    end
  end

endmodule : logic_unit

// File: tb/tb_logic_unit.sv
// Directed-vector bench for logic_unit (WIDTH=8) plus a short randomised stream against a reference model.
`timescale 1ns/1ps
module tb_logic_unit;
  import alu_pkg::*;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         acc_clear;
  logic         in_valid;
  logic         in_ready;
  logic_op_e    in_op;
  logic         in_invert;
  logic         in_acc;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_zero;
  logic         out_parity;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  logic_unit #(.WIDTH(W), .ACC_RESET(8'h00)) dut (
    .clk        (clk),
    .rst        (rst),
    .acc_clear  (acc_clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_invert  (in_invert),
    .in_acc     (in_acc),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_parity (out_parity)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic_op_e op, input logic inv, input logic acc,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid  = v;
    in_op     = op;
    in_invert = inv;
    in_acc    = acc;
    in_a      = a;
    in_b      = b;
  endtask

  task automatic check_out(input string tag, input logic [W-1:0] res, input logic z, input logic p);
    check({tag, "_valid"}, 64'(out_valid), 64'(1'b1));
    check({tag, "_result"}, 64'(out_result), 64'(res));
    check({tag, "_zero"}, 64'(out_zero), 64'(z));
    check({tag, "_parity"}, 64'(out_parity), 64'(p));
  endtask

  function automatic logic [W-1:0] ref_op(input logic_op_e op, input logic inv,
                                          input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    case (op)
      LOP_AND: r = a & b;
      LOP_OR:  r = a | b;
      LOP_XOR: r = a ^ b;
      default: r = a;
    endcase
    return inv ? ~r : r;
  endfunction

  logic [W-1:0] m_res, m_acc, m_aeff, m_r;
  logic         m_valid, m_fire;

  initial begin
    rst = 1'b1; acc_clear = 1'b0; out_ready = 1'b1;
    drive(1'b0, LOP_AND, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    step();
    rst = 1'b0;
    #1;
    check("rst_valid", 64'(out_valid), 64'(1'b0));
    check("rst_result", 64'(out_result), 64'(8'h00));
    check("rst_zero", 64'(out_zero), 64'(1'b0));
    check("rst_parity", 64'(out_parity), 64'(1'b0));
    check("rst_in_ready", 64'(in_ready), 64'(1'b1));

    // OR / NOR / XOR / AND / NOT
    drive(1'b1, LOP_OR, 1'b0, 1'b0, 8'hF0, 8'h0F); step(); check_out("or", 8'hFF, 1'b0, 1'b0);
    drive(1'b1, LOP_OR, 1'b1, 1'b0, 8'hF0, 8'h0F); step(); check_out("nor", 8'h00, 1'b1, 1'b0);
    drive(1'b1, LOP_XOR, 1'b0, 1'b0, 8'hA5, 8'h3C); step(); check_out("xor", 8'h99, 1'b0, 1'b0);
    drive(1'b1, LOP_AND, 1'b0, 1'b0, 8'hA5, 8'h3C); step(); check_out("and", 8'h24, 1'b0, 1'b0);
    drive(1'b1, LOP_PASS_A, 1'b1, 1'b0, 8'hA5, 8'h3C); step(); check_out("not", 8'h5A, 1'b1 & 1'b0, 1'b0);
    drive(1'b1, LOP_XOR, 1'b1, 1'b0, 8'h0F, 8'h08); step(); check_out("xnor", 8'hF8, 1'b0, 1'b1);
    drive(1'b0, LOP_AND, 1'b0, 1'b0, 8'h00, 8'h00); step();
    check("drain_valid", 64'(out_valid), 64'(1'b0));
    check("drain_hold", 64'(out_result), 64'(8'hF8));

    // Back-pressure: first result stalls two cycles, later ones follow in order
    drive(1'b1, LOP_OR, 1'b0, 1'b0, 8'h01, 8'h00); step(); check_out("bp1", 8'h01, 1'b0, 1'b1);
    drive(1'b1, LOP_OR, 1'b0, 1'b0, 8'h02, 8'h00); out_ready = 1'b0; #1;
    check("bp_ready0a", 64'(in_ready), 64'(1'b0));
    step(); check_out("bp_stall1", 8'h01, 1'b0, 1'b1);
    drive(1'b1, LOP_AND, 1'b0, 1'b0, 8'hFF, 8'h00); #1;
    check("bp_ready0b", 64'(in_ready), 64'(1'b0));
    step(); check_out("bp_stall2", 8'h01, 1'b0, 1'b1);
    drive(1'b1, LOP_OR, 1'b0, 1'b0, 8'h02, 8'h00); out_ready = 1'b1; #1;
    check("bp_ready1", 64'(in_ready), 64'(1'b1));
    step(); check_out("bp2", 8'h02, 1'b0, 1'b1);
    drive(1'b1, LOP_OR, 1'b0, 1'b0, 8'h03, 8'h00); step(); check_out("bp3", 8'h03, 1'b0, 1'b0);
    drive(1'b0, LOP_AND, 1'b0, 1'b0, 8'h00, 8'h00); step();
    check("bp_empty", 64'(out_valid), 64'(1'b0));

    // Accumulate
    acc_clear = 1'b1; step(); acc_clear = 1'b0;
    drive(1'b1, LOP_OR, 1'b0, 1'b1, 8'hFF, 8'h01); step(); check_out("acc1", 8'h01, 1'b0, 1'b1);
    drive(1'b1, LOP_OR, 1'b0, 1'b1, 8'hFF, 8'h02); step(); check_out("acc2", 8'h03, 1'b0, 1'b0);
    drive(1'b1, LOP_OR, 1'b0, 1'b1, 8'hFF, 8'h04); step(); check_out("acc3", 8'h07, 1'b0, 1'b1);
    drive(1'b1, LOP_OR, 1'b0, 1'b1, 8'hFF, 8'h80); acc_clear = 1'b1; step(); acc_clear = 1'b0;
    check_out("acc_clr_wb", 8'h80, 1'b0, 1'b1);
    drive(1'b1, LOP_PASS_A, 1'b0, 1'b1, 8'h00, 8'h00); step(); check_out("acc_read80", 8'h80, 1'b0, 1'b1);
    drive(1'b1, LOP_OR, 1'b0, 1'b0, 8'h11, 8'h22); acc_clear = 1'b1; step(); acc_clear = 1'b0;
    check_out("clr_no_acc", 8'h33, 1'b0, 1'b0);
    drive(1'b1, LOP_PASS_A, 1'b0, 1'b1, 8'h55, 8'h00); step(); check_out("acc_read00", 8'h00, 1'b1, 1'b0);
    drive(1'b1, LOP_OR, 1'b0, 1'b1, 8'h00, 8'h0F); step(); check_out("acc_0f", 8'h0F, 1'b0, 1'b0);
    // Stalled accumulate requests must not touch acc until accepted
    out_ready = 1'b0; drive(1'b1, LOP_XOR, 1'b0, 1'b1, 8'h00, 8'hF0); step(); step();
    check_out("acc_stall", 8'h0F, 1'b0, 1'b0);
    out_ready = 1'b1; step(); check_out("acc_after_stall", 8'hFF, 1'b0, 1'b0);

    // Reset mid-stall drops the pending result and the accumulator
    out_ready = 1'b0; drive(1'b0, LOP_AND, 1'b0, 1'b0, 8'h00, 8'h00);
    rst = 1'b1; step(); rst = 1'b0; #1;
    check("rs_valid", 64'(out_valid), 64'(1'b0));
    check("rs_result", 64'(out_result), 64'(8'h00));
    check("rs_zero", 64'(out_zero), 64'(1'b0));
    check("rs_parity", 64'(out_parity), 64'(1'b0));
    check("rs_in_ready", 64'(in_ready), 64'(1'b1));
    out_ready = 1'b1;
    drive(1'b1, LOP_PASS_A, 1'b0, 1'b1, 8'hAA, 8'h00); step(); check_out("rs_acc", 8'h00, 1'b1, 1'b0);
    drive(1'b0, LOP_AND, 1'b0, 1'b0, 8'h00, 8'h00); step();

    // Randomised streaming against the reference model
    rst = 1'b1; step(); rst = 1'b0;
    m_valid = 1'b0; m_acc = 8'h00; m_res = 8'h00;
    for (int i = 0; i < 300; i++) begin
      check("st_valid", 64'(out_valid), 64'(m_valid));
      if (m_valid) begin
        check("st_result", 64'(out_result), 64'(m_res));
        check("st_zero", 64'(out_zero), 64'(m_res == 8'h00));
        check("st_parity", 64'(out_parity), 64'(^m_res));
      end
      drive(1'($urandom_range(0, 3) != 0), logic_op_e'(2'($urandom_range(0, 3))),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
            8'($urandom), 8'($urandom));
      out_ready = 1'($urandom_range(0, 2) != 0);
      acc_clear = 1'($urandom_range(0, 9) == 0);
      #1;
      check("st_in_ready", 64'(in_ready), 64'(!m_valid || out_ready));
      m_aeff = in_acc ? (acc_clear ? 8'h00 : m_acc) : in_a;
      m_r    = ref_op(in_op, in_invert, m_aeff, in_b);
      m_fire = in_valid && (!m_valid || out_ready);
      if (m_fire) begin
        m_res = m_r; m_valid = 1'b1;
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
      if (m_fire && in_acc) m_acc = m_r;
      else if (acc_clear) m_acc = 8'h00;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_logic_unit
